sum_stream: RTL and testbench

- Transmit-side companion to the packed-vector sum reducer.
- Accepts one packed vector of N elements, each DW bits wide, over a valid/ready handshake.
- Streams the elements out one per handshake, element 0 first, and flags the last beat.
- Feeds serial datapaths, such as an accumulator or link, from packed-vector producers in the arithmetic benchmarks.

---
 rtl/sum_stream.sv | 144 ++++++++++++++
 tb/tb_sum_stream.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_stream.sv
// ---------------------------------------------------------------------------
// sum_stream
//   Packed-vector to element-stream serializer. Accepts one packed vector of
//   N elements (DW bits each) over a valid/ready handshake, then emits the
//   elements one per output handshake, element 0 first, flagging the last.
//   in_ready is combinational from out_ready on the final beat so that
//   consecutive vectors stream with no bubble (N beats per vector).
//
//   Optional build macro: SUM_STREAM_PSUM_EN
//     Adds out_psum, the running unsigned prefix sum (mod 2^(DW+IW)) of
//     elements 0..out_idx of the vector being streamed.
//
// Ports
//   clk        in   rising-edge clock
//   nreset     in   asynchronous active-low reset
//   in_valid   in   packed vector available
//   in_ready   out  block can accept a vector
//   in_data    in   N*DW packed vector, element i at [i*DW +: DW]
//   out_valid  out  element beat valid
//   out_ready  in   downstream accepts beat
//   out_data   out  current element (DW)
//   out_idx    out  index of current element (IW)
//   out_last   out  current beat is element N-1
//   out_psum   out  running prefix sum (DW+IW), only with SUM_STREAM_PSUM_EN
// ---------------------------------------------------------------------------
module sum_stream #(
    parameter  int N  = 8,
    parameter  int DW = 16,
    localparam int IW = $clog2(N)
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*DW-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic [IW-1:0]     out_idx,
`ifdef SUM_STREAM_PSUM_EN
    output logic [DW+IW-1:0]  out_psum,
`endif
    output logic              out_last
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [N-1:0][DW-1:0]    buf_q, buf_d;
    logic [IW-1:0]           idx_q, idx_d;

    logic accept;
    logic xfer;

    assign accept = in_valid & in_ready;
    assign xfer   = out_valid & out_ready;

    // ---------------- state register + datapath registers ----------------
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        // Acceptance wins over the index step: in BUSY it only happens on
        // the final transfer, where the next vector restarts at element 0.
        if (accept) begin
            buf_d   = in_data;
            idx_d   = '0;
            state_d = BUSY;
        end else if (xfer) begin
            if (out_last) begin
                state_d = IDLE;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            BUSY: begin
                out_valid = 1'b1;
                out_data  = buf_q[idx_q];
                out_idx   = idx_q;
                out_last  = (idx_q == IW'(N - 1));
                // Reload only as the last beat leaves, keeping the stream gapless.
                in_ready  = out_last & out_ready;
            end
            default: begin
                in_ready = 1'b1;
            end
        endcase
    end

`ifdef SUM_STREAM_PSUM_EN
    // Accumulator holds the sum of elements already transferred; the
    // current element is added combinationally so out_psum includes it.
    logic [DW+IW-1:0] acc_q, acc_d;
    logic [DW+IW-1:0] elem_ext;

    assign elem_ext = {{IW{1'b0}}, out_data};

    always_comb begin
        acc_d = acc_q;
        if (accept) begin
            acc_d = '0;
        end else if (xfer) begin
            acc_d = acc_q + elem_ext;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign out_psum = out_valid ? (acc_q + elem_ext) : '0;
`endif

endmodule

// File: tb/tb_sum_stream.sv
// ---------------------------------------------------------------------------
// tb_sum_stream
//   Scoreboard bench for sum_stream with N=4, DW=8. Every accepted vector is
//   expanded into its expected beat list (data, index, last flag, prefix sum)
//   and queued; a negedge monitor compares the DUT's beats against the queue
//   and checks in_ready/out_valid against the queue occupancy.
// ---------------------------------------------------------------------------
module tb_sum_stream;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic              clk;
    logic              nreset;
    logic              in_valid;
    logic              in_ready;
    logic [N*DW-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [IW-1:0]     out_idx;
    logic              out_last;
`ifdef SUM_STREAM_PSUM_EN
    logic [DW+IW-1:0]  out_psum;
`endif

    sum_stream #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
`ifdef SUM_STREAM_PSUM_EN
        .out_psum  (out_psum),
`endif
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]    d;
        int               idx;
        logic             last;
        logic [DW+IW-1:0] psum;
    } beat_t;

    beat_t q[$];
    int    checks = 0;
    int    errors = 0;
    bit    rnd_on = 1'b0;
    bit    mr;
    beat_t fe;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expand one accepted vector into its expected beats.
    task automatic push_vec(input logic [N*DW-1:0] v);
        logic [DW+IW-1:0] s;
        beat_t b;
        s = '0;
        for (int i = 0; i < N; i++) begin
            b.d    = v[i*DW +: DW];
            s      = s + {{IW{1'b0}}, b.d};
            b.idx  = i;
            b.last = (i == N - 1);
            b.psum = s;
            q.push_back(b);
        end
    endtask

    // Monitor: inputs are stable between the driver's posedge+1 updates, so
    // the negedge view decides what happens at the following posedge.
    always @(negedge clk) begin
        if (nreset) begin
            mr = (q.size() == 0) || (q.size() == 1 && out_ready);
            chk("in_ready", in_ready, mr);
            chk("out_valid", out_valid, q.size() != 0);
            if (out_valid && q.size() > 0) begin
                fe = q[0];
                chk("out_data", out_data, fe.d);
                chk("out_idx", out_idx, fe.idx);
                chk("out_last", out_last, fe.last);
`ifdef SUM_STREAM_PSUM_EN
                chk("out_psum", out_psum, fe.psum);
`endif
                if (out_ready) void'(q.pop_front());
            end else if (!out_valid) begin
                chk("idle_last", out_last, 1'b0);
`ifdef SUM_STREAM_PSUM_EN
                chk("idle_psum", out_psum, 0);
`endif
            end
            if (in_valid && mr) push_vec(in_data);
        end
    end

    // Random output backpressure, enabled only in the random phase.
    always @(posedge clk) begin
        if (rnd_on) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Present a vector until accepted; called at posedge+1.
    task automatic send(input logic [N*DW-1:0] v);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = v;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("send_accept", ok, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("drain", ok, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idx(input int want);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (out_valid && out_idx == want) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("wait_idx", ok, 1'b1);
    endtask

    initial begin
        nreset    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #12;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_out_data", out_data, 0);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        @(posedge clk);
        #1;

        // Basic stream
        send(32'h04030201);
        drain();

        // Back-to-back, in_valid held across both vectors
        send(32'h04030201);
        send(32'h08070605);
        drain();

        // Backpressure at idx 2
        send(32'h04030201);
        wait_idx(2);
        out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain();

        // Reset mid-vector, after beat 1 has transferred
        send(32'h11223344);
        wait_idx(2);
        nreset = 1'b0;
        #1;
        chk("amid_out_valid", out_valid, 1'b0);
        chk("amid_in_ready", in_ready, 1'b1);
        chk("amid_out_idx", out_idx, 0);
        chk("amid_out_data", out_data, 0);
        q.delete();
        @(posedge clk);
        #1;
        nreset = 1'b1;
        @(posedge clk);
        #1;
        send(32'hAABBCCDD);
        drain();

        // Input isolation: in_data changes right after acceptance
        send(32'h5A6B7C8D);
        in_data = 32'hDEADBEEF;
        drain();

        // Prefix-sum vectors (also plain data checks without the feature)
        send(32'hFFFFFFFF);
        send(32'h01010101);
        drain();

        // Random phase
        rnd_on = 1'b1;
        for (int v = 0; v < 40; v++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            send($urandom);
        end
        rnd_on = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
